// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and helpers for the fetch/data memory arbiter.
// Owner encoding doubles as the index of the port in the two-bit request/grant vectors.
package riscv_mem_arbiter_pkg;

  localparam int ARB_ST_LEN = 2;
  localparam int ARB_PORT_I = 0;
  localparam int ARB_PORT_D = 1;

  typedef enum logic [ARB_ST_LEN-1:0] {
    ARB_ST_IDLE = 2'd0,
    ARB_ST_WAIT = 2'd1,
    ARB_ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_I = 1'b0,
    ARB_OWNER_D = 1'b1
  } arb_owner_e;

  // Fetches never drive byte enables; data accesses pass theirs through.
  function automatic logic [3:0] arb_mem_be(input logic is_d, input logic [3:0] be);
    return is_d ? be : 4'b0000;
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a single requester always wins, a tie goes to the
// port that did not win last time. Purely combinational; history lives in the parent.
module riscv_rr_pick2
  import riscv_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  logic w_tie;

  assign w_tie = &req;

  assign gnt[ARB_PORT_I] = req[ARB_PORT_I] & (~w_tie | (last_owner == ARB_OWNER_D));
  assign gnt[ARB_PORT_D] = req[ARB_PORT_D] & (~w_tie | (last_owner == ARB_OWNER_I));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data access,
// one outstanding access at a time, with a fixed memory read latency of MEM_LAT cycles.
//
// state | meaning
// IDLE  | nothing in flight, grants open
// WAIT  | granted access in flight, counting down the memory latency
// RESP  | one-cycle response pulse to the owner, grants open again
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_e       r_state;
  arb_owner_e       r_last_owner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rd_capture;
  logic             r_i_rvalid;
  logic             r_d_rvalid;
  logic             r_busy;
  logic [31:0]      r_i_rdata;
  logic [31:0]      r_d_rdata;

  logic             w_open;
  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic             w_any;
  logic             w_is_d;
  logic             w_unused;

  // Reset also closes the grant path so nothing reaches the RAM while rst is high.
  assign w_open = ~rst & ((r_state == ARB_ST_IDLE) | (r_state == ARB_ST_RESP));
  assign w_req  = {d_req, i_req} & {2{w_open}};

  riscv_rr_pick2 u_pick (
    .req        (w_req),
    .last_owner (r_last_owner),
    .gnt        (w_gnt)
  );

  assign w_any  = |w_gnt;
  assign w_is_d = w_gnt[ARB_PORT_D];

  assign i_gnt   = w_gnt[ARB_PORT_I];
  assign d_gnt   = w_gnt[ARB_PORT_D];
  assign m_en    = w_any;
  assign m_we    = w_is_d & d_we;
  assign m_be    = arb_mem_be(w_is_d, d_be);
  assign m_addr  = w_is_d ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
  assign m_wdata = w_is_d ? d_wdata : 32'h0;

  assign i_rvalid = r_i_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;
  assign busy     = r_busy;

  // Byte-lane bits and the bits above the RAM window are deliberately dropped.
  assign w_unused = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_ST_IDLE;
      r_last_owner <= ARB_OWNER_D;
      r_cnt        <= '0;
      r_rd_capture <= 1'b0;
      r_i_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_busy       <= 1'b0;
      r_i_rdata    <= 32'h0;
      r_d_rdata    <= 32'h0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      case (r_state)
        ARB_ST_IDLE, ARB_ST_RESP: begin
          if (w_any) begin
            r_state      <= ARB_ST_WAIT;
            r_cnt        <= CNT_LOAD;
            r_busy       <= 1'b1;
            r_last_owner <= w_is_d ? ARB_OWNER_D : ARB_OWNER_I;
            r_rd_capture <= ~(w_is_d & d_we);
          end else begin
            r_state <= ARB_ST_IDLE;
          end
        end
        ARB_ST_WAIT: begin
          if (r_cnt == '0) begin
            // Last latency cycle: m_rdata is valid now and lands in the owner's register.
            r_state <= ARB_ST_RESP;
            r_busy  <= 1'b0;
            if (r_last_owner == ARB_OWNER_I) begin
              r_i_rvalid <= 1'b1;
              r_i_rdata  <= m_rdata;
            end else begin
              r_d_rvalid <= 1'b1;
              if (r_rd_capture) begin
                r_d_rdata <= m_rdata;
              end
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ARB_ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
